// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer: state encoding,
// per-stage release delay and the parameter legality rule.
package rst_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_PG = 2'd0,
        COUNT   = 2'd1,
        SETTLE  = 2'd2,
        RUN     = 2'd3
    } seq_state_e;

    // Cycle count (from debounce complete) at which stage k is released.
    function automatic int unsigned stage_dly(input int unsigned base,
                                              input int unsigned step,
                                              input int unsigned k);
        return base + k * step;
    endfunction

    // The last release delay must fit below the counter's all-ones value.
    function automatic bit seq_params_ok(input int unsigned num_stages,
                                         input int unsigned base,
                                         input int unsigned step,
                                         input int unsigned pg_cycles,
                                         input int unsigned cnt_w);
        longint unsigned last;
        if (num_stages < 1 || num_stages > 8 || pg_cycles < 1 || cnt_w < 1)
            return 1'b0;
        last = 64'(base) + 64'(num_stages - 1) * 64'(step);
        if (cnt_w >= 63)
            return 1'b1;
        return last < ((64'd1 << cnt_w) - 64'd1);
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Power-good/soft-request inputs and staged reset outputs of the sequencer.
interface rst_sequencer_if #(
    parameter int unsigned NUM_STAGES = 3
) ();
    logic                  pg_ok;
    logic                  soft_req;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  en;
    logic                  done;
    logic [1:0]            state;

    modport master (
        input  pg_ok,
        input  soft_req,
        output stage_rst,
        output en,
        output done,
        output state
    );

    modport slave (
        output pg_ok,
        output soft_req,
        input  stage_rst,
        input  en,
        input  done,
        input  state
    );
endinterface

// File: rtl/rst_sequencer_pg_debounce.sv
// Power-good stable-high filter: pulses pg_stable once pg_ok has been high for
// PG_CYCLES consecutive edges while active and not cleared.
module pg_debounce #(
    parameter int unsigned PG_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pg_ok_i,
    input  logic clr_i,
    input  logic active_i,
    output logic pg_stable_c_o
);

    localparam int unsigned PG_W = (PG_CYCLES > 1) ? $clog2(PG_CYCLES) : 1;
    localparam logic [PG_W-1:0] PG_LAST = PG_W'(PG_CYCLES - 1);

    logic [PG_W-1:0] pg_cnt_q;
    logic [PG_W-1:0] pg_cnt_d;
    logic            counting_c;
    logic            hit_c;

    // Any low, clear or inactive cycle restarts the stable-time count.
    always_comb begin
        counting_c = active_i && pg_ok_i && !clr_i;
        hit_c      = counting_c && (pg_cnt_q == PG_LAST);
        pg_cnt_d   = '0;
        if (counting_c && !hit_c)
            pg_cnt_d = pg_cnt_q + PG_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            pg_cnt_q <= '0;
        else
            pg_cnt_q <= pg_cnt_d;
    end

    assign pg_stable_c_o = hit_c;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: debounces power-good, releases stage resets at
// BASE_DLY + k*STEP_DLY, then raises a global enable with a one-cycle done.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned BASE_DLY   = 50,
    parameter int unsigned STEP_DLY   = 10,
    parameter int unsigned PG_CYCLES  = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic            sys_clk,
    input  logic            RST,
    rst_sequencer_if.master bus
);

    localparam int unsigned LAST_DLY = stage_dly(BASE_DLY, STEP_DLY, NUM_STAGES - 1);

    if (!seq_params_ok(NUM_STAGES, BASE_DLY, STEP_DLY, PG_CYCLES, CNT_W)) begin : g_param_check
        $error("rst_sequencer: illegal parameter combination");
    end

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;
    logic                  abort_c;
    logic                  wait_pg_c;
    logic                  clr_c;
    logic                  pg_stable_c;

    assign wait_pg_c = (state_q == WAIT_PG);
    assign abort_c   = !wait_pg_c && (!bus.pg_ok || bus.soft_req);
    assign clr_c     = bus.soft_req || abort_c;

    pg_debounce #(
        .PG_CYCLES (PG_CYCLES)
    ) u_debounce (
        .clk_i         (sys_clk),
        .rst_i         (RST),
        .pg_ok_i       (bus.pg_ok),
        .clr_i         (clr_c),
        .active_i      (wait_pg_c),
        .pg_stable_c_o (pg_stable_c)
    );

    // Next-state: abort outranks normal sequencing; done is a single-cycle pulse.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_rst_d = stage_rst_q;
        en_d        = en_q;
        done_d      = 1'b0;

        if (abort_c) begin
            state_d     = WAIT_PG;
            cnt_d       = '0;
            stage_rst_d = '1;
            en_d        = 1'b0;
        end else begin
            case (state_q)
                WAIT_PG: begin
                    if (pg_stable_c) begin
                        state_d = COUNT;
                        cnt_d   = '0;
                    end
                end
                COUNT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                        if (cnt_q == CNT_W'(stage_dly(BASE_DLY, STEP_DLY, k)))
                            stage_rst_d[k] = 1'b0;
                    end
                    if (cnt_q == CNT_W'(LAST_DLY))
                        state_d = SETTLE;
                end
                SETTLE: begin
                    en_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = RUN;
                end
                RUN: begin
                end
                default: state_d = WAIT_PG;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (RST) begin
            state_q     <= WAIT_PG;
            cnt_q       <= '0;
            stage_rst_q <= '1;
            en_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_rst_q <= stage_rst_d;
            en_q        <= en_d;
            done_q      <= done_d;
        end
    end

    assign bus.stage_rst = stage_rst_q;
    assign bus.en        = en_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default and zero-delay configurations driven by the
// same stimulus, checked against an age-based reference model via scoreboards.
module tb_rst_sequencer;

    // Config A: defaults. Config B: four stages, zero delays, single-cycle debounce.
    localparam int unsigned A_NS = 3, A_BASE = 50, A_STEP = 10, A_PG = 4;
    localparam int unsigned B_NS = 4, B_BASE = 0,  B_STEP = 0,  B_PG = 1;
    localparam int unsigned AGE_CAP = 1000;

    typedef struct packed {
        logic [7:0] srst;
        logic       en;
        logic       done;
        logic [1:0] st;
    } obs_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic pg_ok    = 1'b0;
    logic soft_req = 1'b0;

    always #5 clk = ~clk;

    rst_sequencer_if #(.NUM_STAGES(A_NS)) if_a ();
    rst_sequencer_if #(.NUM_STAGES(B_NS)) if_b ();

    assign if_a.pg_ok    = pg_ok;
    assign if_a.soft_req = soft_req;
    assign if_b.pg_ok    = pg_ok;
    assign if_b.soft_req = soft_req;

    rst_sequencer #(
        .NUM_STAGES (A_NS), .BASE_DLY (A_BASE), .STEP_DLY (A_STEP),
        .PG_CYCLES  (A_PG), .CNT_W    (32)
    ) dut_a (
        .sys_clk (clk),
        .RST     (rst),
        .bus     (if_a)
    );

    rst_sequencer #(
        .NUM_STAGES (B_NS), .BASE_DLY (B_BASE), .STEP_DLY (B_STEP),
        .PG_CYCLES  (B_PG), .CNT_W    (8)
    ) dut_b (
        .sys_clk (clk),
        .RST     (rst),
        .bus     (if_b)
    );

    obs_t        exp_a_q[$];
    obs_t        exp_b_q[$];
    int unsigned age;
    int          errors = 0;
    int          checks = 0;
    int          cycle  = 0;

    // Outputs depend only on how many consecutive clean edges (RST low, pg_ok
    // high, soft_req low) have elapsed; any other edge restarts from zero.
    function automatic obs_t model(input int unsigned a, input int unsigned ns,
                                   input int unsigned base, input int unsigned step,
                                   input int unsigned pgc);
        obs_t        o;
        int unsigned last;
        last   = base + (ns - 1) * step;
        o.srst = '0;
        for (int unsigned k = 0; k < 8; k++)
            if (k < ns)
                o.srst[k] = (a < pgc + base + k * step + 1);
        o.en   = (a >= pgc + last + 2);
        o.done = (a == pgc + last + 2);
        if (a < pgc)                 o.st = 2'd0;
        else if (a < pgc + last + 1) o.st = 2'd1;
        else if (a == pgc + last + 1) o.st = 2'd2;
        else                         o.st = 2'd3;
        return o;
    endfunction

    task automatic drive(input logic r, input logic p, input logic s);
        @(negedge clk);
        rst      = r;
        pg_ok    = p;
        soft_req = s;
        if (r || !p || s)
            age = 0;
        else if (age < AGE_CAP)
            age = age + 1;
        exp_a_q.push_back(model(age, A_NS, A_BASE, A_STEP, A_PG));
        exp_b_q.push_back(model(age, B_NS, B_BASE, B_STEP, B_PG));
    endtask

    task automatic hold(input int n, input logic r, input logic p, input logic s);
        for (int i = 0; i < n; i++)
            drive(r, p, s);
    endtask

    // Monitor: every edge the DUTs present a new output set; pop and compare.
    obs_t got_a, got_b, want_a, want_b;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_a_q.size() != 0) begin
                want_a = exp_a_q.pop_front();
                got_a  = {5'b0, if_a.stage_rst, if_a.en, if_a.done, if_a.state};
                checks++;
                if (got_a !== want_a) begin
                    errors++;
                    $display("FAIL seq_a cycle %0d: got rst=%b en=%b done=%b st=%0d, want rst=%b en=%b done=%b st=%0d",
                             cycle, got_a.srst, got_a.en, got_a.done, got_a.st,
                             want_a.srst, want_a.en, want_a.done, want_a.st);
                end
            end
            if (exp_b_q.size() != 0) begin
                want_b = exp_b_q.pop_front();
                got_b  = {4'b0, if_b.stage_rst, if_b.en, if_b.done, if_b.state};
                checks++;
                if (got_b !== want_b) begin
                    errors++;
                    $display("FAIL seq_b cycle %0d: got rst=%b en=%b done=%b st=%0d, want rst=%b en=%b done=%b st=%0d",
                             cycle, got_b.srst, got_b.en, got_b.done, got_b.st,
                             want_b.srst, want_b.en, want_b.done, want_b.st);
                end
            end
        end
    end

    initial begin
        int len;
        int kind;
        age = 0;

        // Power-up: full sequence through RUN.
        hold(3, 1'b1, 1'b1, 1'b0);
        hold(90, 1'b0, 1'b1, 1'b0);

        // Short pg_ok glitch during debounce.
        hold(2, 1'b1, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b0, 1'b0);
        hold(90, 1'b0, 1'b1, 1'b0);

        // Soft request after stage 0 release.
        hold(2, 1'b1, 1'b1, 1'b0);
        hold(60, 1'b0, 1'b1, 1'b0);
        hold(1, 1'b0, 1'b1, 1'b1);
        hold(90, 1'b0, 1'b1, 1'b0);

        // Power-good loss in RUN, then recovery.
        hold(1, 1'b0, 1'b0, 1'b0);
        hold(90, 1'b0, 1'b1, 1'b0);

        // RST mid-COUNT, then restart as from power-up.
        hold(2, 1'b1, 1'b1, 1'b0);
        hold(59, 1'b0, 1'b1, 1'b0);
        hold(1, 1'b1, 1'b1, 1'b0);
        hold(90, 1'b0, 1'b1, 1'b0);

        // Held soft_req keeps the block waiting.
        hold(20, 1'b0, 1'b1, 1'b1);
        hold(85, 1'b0, 1'b1, 1'b0);

        // Randomized clean stretches separated by random disturbances.
        for (int seg = 0; seg < 40; seg++) begin
            len = int'($urandom_range(1, 100));
            hold(len, 1'b0, 1'b1, 1'b0);
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       hold(int'($urandom_range(1, 5)), 1'b0, 1'b0, 1'b0);
                1:       hold(int'($urandom_range(1, 3)), 1'b0, 1'b1, 1'b1);
                2:       hold(int'($urandom_range(1, 2)), 1'b1, $urandom_range(0, 1) == 1, 1'b0);
                default: hold(int'($urandom_range(1, 4)), 1'b0,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            endcase
        end
        hold(80, 1'b0, 1'b1, 1'b0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_a_q.size() + exp_b_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0",
                     exp_a_q.size() + exp_b_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
Parametrised power-on/soft reset sequencer for the USART system; successor to the fixed 50-cycle enable/reset delay generator.
- Filters a power-good input for a programmable stable time.
- Releases NUM_STAGES active-high reset outputs in staggered order, then raises a global enable.
- Re-runs the full sequence on power-good loss or a soft reset request.
- Sits at top level and drives the resets of the baud generator, TX/RX engines and application logic.

Parameters:
NUM_STAGES, 3, number of staged reset outputs (1..8)
BASE_DLY, 50, cycles from debounce-complete to release of stage 0
STEP_DLY, 10, additional cycles between consecutive stage releases (0 allowed: simultaneous release)
PG_CYCLES, 4, consecutive high cycles of pg_ok required before counting (>=1)
CNT_W, 32, sequence counter width; BASE_DLY+(NUM_STAGES-1)*STEP_DLY must be < 2^CNT_W-1

Ports:
sys_clk  input  1  system clock; all logic on rising edge
RST  input  1  reset, synchronous, active-high
pg_ok  input  1  power-good/PLL-lock, already synchronous to sys_clk
soft_req  input  1  soft reset request, sampled each edge
stage_rst  output  NUM_STAGES  per-stage reset, active-high; bit k released at delay D_k = BASE_DLY + k*STEP_DLY
en  output  1  global enable, high only when all stages are released
done  output  1  one-cycle pulse when en rises
state  output  2  current FSM state, for debug

Behaviour:
- Priority at every edge: RST > abort > normal sequencing.
- RST high at an edge sets: stage_rst = all ones, en = 0, done = 0, state = WAIT_PG, pg_cnt = 0, cnt = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States (encoding in package): WAIT_PG=0, COUNT=1, SETTLE=2, RUN=3.
- WAIT_PG:
  - pg_ok=1: pg_cnt++. If pg_cnt==PG_CYCLES-1, go to COUNT and set cnt<=0.
  - pg_ok=0 or soft_req=1: pg_cnt<=0, remain in WAIT_PG.
- COUNT:
  - cnt++ each edge.
  - For each k with cnt==D_k: stage_rst[k]<=0.
  - When cnt==D_{NUM_STAGES-1}: go to SETTLE.
  - Stages with equal D_k release on the same edge.
- SETTLE (one cycle): en<=1, done<=1, go to RUN.
- RUN: done<=0; en and stage_rst hold.
- Abort, in COUNT/SETTLE/RUN, when pg_ok=0 or soft_req=1 at an edge:
  - stage_rst<=all ones, en<=0, done<=0, cnt<=0, pg_cnt<=0, state<=WAIT_PG.
  - Released stages re-assert on that same edge.
- Timing, T0 = first edge with RST low, pg_ok held high from T0:
  - stage_rst[k] falls after edge T0+PG_CYCLES+D_k.
  - en rises and done pulses after edge T0+PG_CYCLES+D_last+1.
- cnt never wraps: COUNT exits before overflow. The parameter rule is enforced by an elaboration-time check.
- soft_req held high keeps the block in WAIT_PG with pg_cnt=0. The sequence starts once soft_req drops.
- A pg_ok glitch shorter than PG_CYCLES during WAIT_PG restarts debounce and produces no output change.
- RST mid-sequence returns to the reset values on the next edge. The restart is identical to power-up.

Decomposition:
- Shared package/header rst_seq_pkg holds:
  - state encodings;
  - state width (2);
  - the D_k stage-delay function/macro;
  - the parameter-legality check.
- One natural sub-module, pg_debounce: the PG_CYCLES stable-high filter with synchronous clear (soft_req/abort). It outputs a one-cycle pg_stable pulse that advances WAIT_PG to COUNT.

Test Plan:
- Defaults, RST high 3 cycles then low (T0), pg_ok=1 -> stage_rst 3'b111 until T0+54; 3'b110 after T0+54; 3'b100 after T0+64; 3'b000 after T0+74; en=1 and done=1 for exactly one cycle after T0+75.
- pg_ok low for 2 cycles at T0+2 (PG_CYCLES=4) -> debounce restarts; all release times shift by 4 cycles; no output changes during the glitch.
- soft_req pulse at T0+60 (stage0 released) -> next edge stage_rst=3'b111, en=0, state=WAIT_PG; full sequence reruns measured from the edge soft_req drops.
- pg_ok drop in RUN -> stage_rst=all ones and en=0 after that edge; done never pulses during the abort; recovery takes PG_CYCLES+D_last+2 cycles after pg_ok returns.
- STEP_DLY=0, NUM_STAGES=4, BASE_DLY=0, PG_CYCLES=1 -> all four stages release on the same edge T0+1; en rises after T0+2.
- RST asserted during COUNT at T0+59 -> outputs return to reset values after that edge; state=0; identical timing to power-up after RST falls.
